// File: rtl/prize_hit_detector.sv
// prize_hit_detector
// Watches Bumpy/prize drawing requests during a frame, latches the grid tile of
// the first overlap and, at the next frame boundary, issues one registered
// prize_collision pulse carrying that tile's row, column and type. A frame
// cooldown after each pulse keeps a single touch from clearing a tile twice.
//
// Ports:
//   clk              system clock
//   resetN           synchronous active-low reset
//   startOfFrame     one-cycle frame-start strobe
//   pixelX, pixelY   current VGA pixel coordinates (11 bits)
//   bumpyDR          Bumpy drawing request at the current pixel
//   prizeDR          prize drawing request at the current pixel
//   prize_type       map contents at the current tile (0 = FREE)
//   prize_collision  registered pulse, PULSE_CYCLES cycles long
//   hit_row/col/type tile and type of the collected prize, held between pulses
//   prize_count      collected prizes, saturating at 255
module prize_hit_detector #(
    parameter int unsigned NUM_OF_ROWS     = 7,
    parameter int unsigned NUM_OF_COLS     = 10,
    parameter int unsigned TILE_SHIFT      = 6,
    parameter int unsigned PULSE_CYCLES    = 4,
    parameter int unsigned COOLDOWN_FRAMES = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        bumpyDR,
    input  logic        prizeDR,
    input  logic [2:0]  prize_type,
    output logic        prize_collision,
    output logic [2:0]  hit_row,
    output logic [3:0]  hit_col,
    output logic [2:0]  hit_type,
    output logic [7:0]  prize_count
);

    localparam int unsigned PIX_W   = 11;
    localparam int unsigned ROW_W   = 3;
    localparam int unsigned COL_W   = 4;
    localparam int unsigned TYPE_W  = 3;
    localparam int unsigned PCNT_W  = 4;
    localparam int unsigned CD_W    = 3;
    localparam int unsigned COUNT_W = 8;

    localparam logic [PCNT_W-1:0]  PULSE_LOAD = PCNT_W'(PULSE_CYCLES - 1);
    localparam logic [CD_W-1:0]    CD_LOAD    = CD_W'(COOLDOWN_FRAMES);
    localparam logic [COUNT_W-1:0] COUNT_MAX  = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        PULSE    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                hit_seen_q, hit_seen_d;
    logic [ROW_W-1:0]    pend_row_q, pend_row_d;
    logic [COL_W-1:0]    pend_col_q, pend_col_d;
    logic [TYPE_W-1:0]   pend_type_q, pend_type_d;
    logic [PCNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [CD_W-1:0]     cd_cnt_q, cd_cnt_d;
    logic                prize_collision_d;
    logic [ROW_W-1:0]    hit_row_d;
    logic [COL_W-1:0]    hit_col_d;
    logic [TYPE_W-1:0]   hit_type_d;
    logic [COUNT_W-1:0]  prize_count_d;

    // Tile index of the current pixel, truncated to the grid field widths
    logic [PIX_W-1:0]    row_full_c, col_full_c;
    logic [ROW_W-1:0]    tile_row_c;
    logic [COL_W-1:0]    tile_col_c;
    logic                qualified_c;
    logic                unused_tile_bits_c;

    assign row_full_c  = pixelY >> TILE_SHIFT;
    assign col_full_c  = pixelX >> TILE_SHIFT;
    assign tile_row_c  = row_full_c[ROW_W-1:0];
    assign tile_col_c  = col_full_c[COL_W-1:0];
    assign unused_tile_bits_c = ^{row_full_c[PIX_W-1:ROW_W], col_full_c[PIX_W-1:COL_W]};

    // Overlaps on the frame-start cycle are blanking/first pixels and are dropped
    assign qualified_c = bumpyDR & prizeDR & (prize_type != '0)
                       & (32'(tile_row_c) < NUM_OF_ROWS)
                       & (32'(tile_col_c) < NUM_OF_COLS)
                       & ~startOfFrame;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q         <= ARMED;
            hit_seen_q      <= 1'b0;
            pend_row_q      <= '0;
            pend_col_q      <= '0;
            pend_type_q     <= '0;
            pulse_cnt_q     <= '0;
            cd_cnt_q        <= '0;
            prize_collision <= 1'b0;
            hit_row         <= '0;
            hit_col         <= '0;
            hit_type        <= '0;
            prize_count     <= '0;
        end else begin
            state_q         <= state_d;
            hit_seen_q      <= hit_seen_d;
            pend_row_q      <= pend_row_d;
            pend_col_q      <= pend_col_d;
            pend_type_q     <= pend_type_d;
            pulse_cnt_q     <= pulse_cnt_d;
            cd_cnt_q        <= cd_cnt_d;
            prize_collision <= prize_collision_d;
            hit_row         <= hit_row_d;
            hit_col         <= hit_col_d;
            hit_type        <= hit_type_d;
            prize_count     <= prize_count_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d           = state_q;
        hit_seen_d        = hit_seen_q;
        pend_row_d        = pend_row_q;
        pend_col_d        = pend_col_q;
        pend_type_d       = pend_type_q;
        pulse_cnt_d       = pulse_cnt_q;
        cd_cnt_d          = cd_cnt_q;
        prize_collision_d = prize_collision;
        hit_row_d         = hit_row;
        hit_col_d         = hit_col;
        hit_type_d        = hit_type;
        prize_count_d     = prize_count;

        unique case (state_q)
            ARMED: begin
                if (startOfFrame) begin
                    if (hit_seen_q) begin
                        hit_row_d         = pend_row_q;
                        hit_col_d         = pend_col_q;
                        hit_type_d        = pend_type_q;
                        prize_collision_d = 1'b1;
                        hit_seen_d        = 1'b0;
                        pulse_cnt_d       = PULSE_LOAD;
                        if (prize_count != COUNT_MAX) begin
                            prize_count_d = prize_count + COUNT_W'(1);
                        end
                        state_d           = PULSE;
                    end
                end else if (qualified_c && !hit_seen_q) begin
                    // First qualified overlap in raster order wins the frame
                    hit_seen_d  = 1'b1;
                    pend_row_d  = tile_row_c;
                    pend_col_d  = tile_col_c;
                    pend_type_d = prize_type;
                end
            end

            PULSE: begin
                if (pulse_cnt_q != '0) begin
                    pulse_cnt_d = pulse_cnt_q - PCNT_W'(1);
                end else begin
                    prize_collision_d = 1'b0;
                    if (COOLDOWN_FRAMES == 0) begin
                        state_d = ARMED;
                    end else begin
                        cd_cnt_d = CD_LOAD;
                        state_d  = COOLDOWN;
                    end
                end
            end

            COOLDOWN: begin
                if (startOfFrame) begin
                    cd_cnt_d = cd_cnt_q - CD_W'(1);
                    if (cd_cnt_q <= CD_W'(1)) begin
                        state_d = ARMED;
                    end
                end
            end

            default: begin
                state_d           = ARMED;
                hit_seen_d        = 1'b0;
                prize_collision_d = 1'b0;
            end
        endcase
    end

endmodule
